// File: rtl/hack_decode_stage.sv
// Hack CPU decode stage: combinational decode into a two-entry output/skid
// buffer with registered in_ready, flush, and a saturating illegal counter.
module hack_decode_stage #(
  parameter int PC_W   = 15,
  parameter int STRICT = 1,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  out_pc,
  output logic             out_is_c,
  output logic [14:0]      out_imm,
  output logic             out_load_a,
  output logic             out_load_d,
  output logic             out_write_m,
  output logic             out_sel_m,
  output logic [5:0]       out_alu,
  output logic [2:0]       out_jcond,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_count
);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            is_c;
    logic [14:0]     imm;
    logic            load_a;
    logic            load_d;
    logic            write_m;
    logic            sel_m;
    logic [5:0]      alu;
    logic [2:0]      jcond;
    logic            illegal;
  } beat_t;

  // The a=1 comp set is a subset of the a=0 set; the rest are M-less only.
  function automatic logic comp_ok(input logic a, input logic [5:0] c);
    case (c)
      6'b110000, 6'b110001, 6'b110011, 6'b110111, 6'b110010,
      6'b000010, 6'b010011, 6'b000111, 6'b000000, 6'b010101: comp_ok = 1'b1;
      6'b101010, 6'b111111, 6'b111010, 6'b001100,
      6'b001101, 6'b001111, 6'b011111, 6'b001110:            comp_ok = !a;
      default:                                               comp_ok = 1'b0;
    endcase
  endfunction

  beat_t dec, or_q, sk_q;
  logic  or_v, sk_v, rdy_q, legal, accept, or_free;

  always_comb begin
    dec    = '0;
    legal  = 1'b1;
    dec.pc = in_pc;
    if (!in_instr[15]) begin
      dec.imm    = in_instr[14:0];
      dec.load_a = 1'b1;
    end else begin
      legal = comp_ok(in_instr[12], in_instr[11:6]) &&
              ((STRICT == 0) || (in_instr[14:13] == 2'b11));
      dec.is_c    = 1'b1;
      dec.sel_m   = in_instr[12];
      dec.alu     = in_instr[11:6];
      dec.illegal = !legal;
      if (legal) begin
        dec.load_a  = in_instr[5];
        dec.load_d  = in_instr[4];
        dec.write_m = in_instr[3];
        dec.jcond   = in_instr[2:0];
      end
    end
  end

  assign accept  = in_valid && rdy_q && !flush;
  assign or_free = !or_v || out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      or_q  <= '0;
      sk_q  <= '0;
      or_v  <= 1'b0;
      sk_v  <= 1'b0;
      rdy_q <= 1'b1;
    end else if (flush) begin
      or_v  <= 1'b0;
      sk_v  <= 1'b0;
      rdy_q <= 1'b1;
    end else if (or_free) begin
      if (sk_v) begin
        // Skid drains first so order is preserved; a new beat takes its place.
        or_q  <= sk_q;
        or_v  <= 1'b1;
        sk_v  <= accept;
        rdy_q <= !accept;
        if (accept) sk_q <= dec;
      end else begin
        or_v  <= accept;
        rdy_q <= 1'b1;
        if (accept) or_q <= dec;
      end
    end else if (accept) begin
      sk_q  <= dec;
      sk_v  <= 1'b1;
      rdy_q <= 1'b0;
    end else begin
      rdy_q <= !sk_v;
    end
  end

  // Delivered illegal beats count even in a flush cycle.
  always_ff @(posedge clk) begin
    if (reset)
      illegal_count <= '0;
    else if (or_v && out_ready && or_q.illegal && (illegal_count != {CNT_W{1'b1}}))
      illegal_count <= illegal_count + 1'b1;
  end

  assign in_ready    = rdy_q;
  assign out_valid   = or_v;
  assign out_pc      = or_q.pc;
  assign out_is_c    = or_q.is_c;
  assign out_imm     = or_q.imm;
  assign out_load_a  = or_q.load_a;
  assign out_load_d  = or_q.load_d;
  assign out_write_m = or_q.write_m;
  assign out_sel_m   = or_q.sel_m;
  assign out_alu     = or_q.alu;
  assign out_jcond   = or_q.jcond;
  assign out_illegal = or_q.illegal;

endmodule

// File: tb/tb_hack_decode_stage.sv
// Scoreboard bench: two decode stages (STRICT=1/CNT_W=8, STRICT=0/CNT_W=2)
// share stimulus and are checked against a list-based reference decoder.
module tb_hack_decode_stage;

  typedef struct packed {
    logic [14:0] pc;
    logic        is_c;
    logic [14:0] imm;
    logic        la, ld, wm, sm;
    logic [5:0]  alu;
    logic [2:0]  jc;
    logic        ill;
  } exp_t;

  typedef struct packed {
    logic [15:0] ins;
    logic [14:0] pc;
  } sb_t;

  logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [15:0] in_instr = '0;
  logic [14:0] in_pc = '0;

  logic        ir1, ov1, ic1, la1, ld1, wm1, sm1, il1;
  logic [14:0] pc1, im1;
  logic [5:0]  al1;
  logic [2:0]  jc1;
  logic [7:0]  cnt1;
  logic        ir2, ov2, ic2, la2, ld2, wm2, sm2, il2;
  logic [14:0] pc2, im2;
  logic [5:0]  al2;
  logic [2:0]  jc2;
  logic [1:0]  cnt2;

  hack_decode_stage #(.PC_W(15), .STRICT(1), .CNT_W(8)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir1), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(ov1), .out_ready(out_ready), .out_pc(pc1),
    .out_is_c(ic1), .out_imm(im1), .out_load_a(la1), .out_load_d(ld1), .out_write_m(wm1),
    .out_sel_m(sm1), .out_alu(al1), .out_jcond(jc1), .out_illegal(il1), .illegal_count(cnt1));

  hack_decode_stage #(.PC_W(15), .STRICT(0), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir2), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(ov2), .out_ready(out_ready), .out_pc(pc2),
    .out_is_c(ic2), .out_imm(im2), .out_load_a(la2), .out_load_d(ld2), .out_write_m(wm2),
    .out_sel_m(sm2), .out_alu(al2), .out_jcond(jc2), .out_illegal(il2), .illegal_count(cnt2));

  always #5 clk = ~clk;

  int   total = 0, bad = 0;
  sb_t  q[$];
  int   m1 = 0, m2 = 0;
  logic mon_en = 1'b0, stalled = 1'b0;
  exp_t held;

  logic [5:0] leg0 [18] = '{6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000, 6'b001101,
                            6'b110001, 6'b001111, 6'b110011, 6'b011111, 6'b110111, 6'b001110,
                            6'b110010, 6'b000010, 6'b010011, 6'b000111, 6'b000000, 6'b010101};
  logic [5:0] leg1 [10] = '{6'b110000, 6'b110001, 6'b110011, 6'b110111, 6'b110010,
                            6'b000010, 6'b010011, 6'b000111, 6'b000000, 6'b010101};

  function automatic exp_t ref_dec(input logic [15:0] i, input logic [14:0] pc, input bit strict);
    exp_t e = '0;
    bit ok = 0;
    e.pc = pc;
    if (i[15] == 1'b0) begin
      e.imm = i[14:0];
      e.la  = 1'b1;
      return e;
    end
    if (i[12]) begin
      foreach (leg1[k]) if (leg1[k] == i[11:6]) ok = 1;
    end else begin
      foreach (leg0[k]) if (leg0[k] == i[11:6]) ok = 1;
    end
    if (strict && i[14:13] != 2'b11) ok = 0;
    e.is_c = 1'b1;
    e.sm   = i[12];
    e.alu  = i[11:6];
    e.ill  = !ok;
    if (ok) begin
      e.la = i[5]; e.ld = i[4]; e.wm = i[3]; e.jc = i[2:0];
    end
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  exp_t a1, a2;
  assign a1 = {pc1, ic1, im1, la1, ld1, wm1, sm1, al1, jc1, il1};
  assign a2 = {pc2, ic2, im2, la2, ld2, wm2, sm2, al2, jc2, il2};

  // Monitor: state invariants against queue depth, then pop on handshake.
  always @(negedge clk) begin
    if (mon_en) begin
      sb_t e;
      chk("out_valid1", 64'(ov1), 64'(q.size() != 0));
      chk("out_valid2", 64'(ov2), 64'(q.size() != 0));
      chk("in_ready1", 64'(ir1), 64'(q.size() < 2));
      chk("in_ready2", 64'(ir2), 64'(q.size() < 2));
      chk("count1", 64'(cnt1), 64'(m1));
      chk("count2", 64'(cnt2), 64'(m2));
      if (stalled) chk("stable", 64'(a1), 64'(held));
      stalled = ov1 && !out_ready && !reset && !flush;
      held    = a1;
      if (ov1 && out_ready && q.size() != 0) begin
        exp_t r1, r2;
        e  = q.pop_front();
        r1 = ref_dec(e.ins, e.pc, 1'b1);
        r2 = ref_dec(e.ins, e.pc, 1'b0);
        chk("beat_strict", 64'(a1), 64'(r1));
        chk("beat_loose", 64'(a2), 64'(r2));
        if (r1.ill && m1 != 255) m1++;
        if (r2.ill && m2 != 3) m2++;
      end
    end
  end

  // Drive one cycle (entered at posedge+1), update the model just before the edge.
  task automatic cyc(input logic v, input logic [15:0] ins, input logic [14:0] pc,
                     input logic rdy, input logic fl, input logic rst);
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = rdy; flush = fl; reset = rst;
    #7;
    if (rst) begin
      q.delete(); m1 = 0; m2 = 0; stalled = 1'b0;
    end else if (fl) begin
      q.delete();
    end else if (v && ir1) begin
      q.push_back('{ins: ins, pc: pc});
    end
    @(posedge clk); #1;
  endtask

  logic [15:0] r_ins;
  initial begin
    @(posedge clk); #1;
    mon_en = 1'b1;
    cyc(0, 16'h0, 0, 1, 0, 1);
    // Basic A/C decode, M=M-1, D;JMP
    cyc(1, 16'h0005, 0, 1, 0, 0);
    cyc(1, 16'hEC10, 1, 1, 0, 0);
    cyc(1, 16'hFC88, 2, 1, 0, 0);
    cyc(1, 16'hE307, 3, 1, 0, 0);
    // Illegal comp, non-11 prefix (illegal strict / D=A loose)
    cyc(1, 16'hE800, 4, 1, 0, 0);
    cyc(1, 16'h8C10, 5, 1, 0, 0);
    cyc(0, 16'h0, 0, 1, 0, 0);
    // Backpressure: offer 3 beats, only two fit
    cyc(1, 16'h0011, 6, 0, 0, 0);
    cyc(1, 16'hE088, 7, 0, 0, 0);
    cyc(1, 16'h0022, 8, 0, 0, 0);
    cyc(1, 16'h0022, 8, 0, 0, 0);
    cyc(1, 16'h0022, 8, 1, 0, 0);
    cyc(0, 16'h0, 0, 1, 0, 0);
    cyc(0, 16'h0, 0, 1, 0, 0);
    // Flush with two buffered plus an input beat
    cyc(1, 16'h0033, 9, 0, 0, 0);
    cyc(1, 16'hE800, 10, 0, 0, 0);
    cyc(1, 16'h0044, 11, 0, 1, 0);
    cyc(0, 16'h0, 0, 1, 0, 0);
    // Mid-stream reset drops buffered beats
    cyc(1, 16'h0055, 12, 0, 0, 0);
    cyc(1, 16'h0066, 13, 0, 0, 1);
    cyc(0, 16'h0, 0, 1, 0, 0);
    // Five illegal beats: loose counter saturates at 3
    for (int k = 0; k < 5; k++) cyc(1, 16'hE800, 15'(20 + k), 1, 0, 0);
    cyc(0, 16'h0, 0, 1, 0, 0);
    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: r_ins = {1'b0, 15'($urandom)};
        3:       r_ins = 16'($urandom);
        default: r_ins = {3'b111, 13'($urandom)};
      endcase
      cyc($urandom_range(0, 3) != 0, r_ins, 15'($urandom), $urandom_range(0, 2) != 0,
          $urandom_range(0, 29) == 0, $urandom_range(0, 499) == 0);
    end
    cyc(0, 16'h0, 0, 1, 0, 0);
    cyc(0, 16'h0, 0, 1, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
